// File: rtl/nonce_scan.sv
// Scans NUM_NONCES hash words from memory, tracks the minimum hash/nonce and counts hits below target,
// then writes a 3-word result record. Latency: done rises NUM_NONCES+5 cycles after start; start ignored while busy.
module nonce_scan #(
    parameter int NUM_NONCES = 16,
    parameter int CW         = $clog2(NUM_NONCES + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [15:0]   input_addr,
    input  logic [15:0]   output_addr,
    input  logic [31:0]   target,
    output logic          mem_clk,
    output logic          mem_we,
    output logic [15:0]   mem_addr,
    output logic [31:0]   mem_write_data,
    input  logic [31:0]   mem_read_data,
    output logic          done,
    output logic          found,
    output logic [31:0]   best_hash,
    output logic [31:0]   best_nonce,
    output logic [CW-1:0] hit_count
);
    localparam int IW = (NUM_NONCES > 2) ? $clog2(NUM_NONCES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NUM_NONCES - 1);

    typedef enum logic [2:0] {IDLE, READ, DRAIN, WR0, WR1, WR2, FIN} state_t;

    state_t          state;
    logic [IW-1:0]   iss_cnt;
    logic [IW-1:0]   cap_cnt;
    // rd_vld[0]: address issued this edge; rd_vld[1]: its data is on mem_read_data next edge
    logic [1:0]      rd_vld;
    logic            capture;

    assign mem_clk = clk;
    assign capture = (state == READ || state == DRAIN) && rd_vld[1];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state          <= IDLE;
            iss_cnt        <= '0;
            cap_cnt        <= '0;
            rd_vld         <= '0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_write_data <= '0;
            done           <= 1'b0;
            found          <= 1'b0;
            best_hash      <= '0;
            best_nonce     <= '0;
            hit_count      <= '0;
        end else begin
            rd_vld <= {rd_vld[0], 1'b0};

            if (capture) begin
                // First word seeds the minimum; strict compare keeps the earliest nonce on ties
                if (cap_cnt == '0 || mem_read_data < best_hash) begin
                    best_hash  <= mem_read_data;
                    best_nonce <= 32'(cap_cnt);
                end
                if (mem_read_data < target)
                    hit_count <= hit_count + CW'(1);
                cap_cnt <= cap_cnt + IW'(1);
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        mem_addr  <= input_addr;
                        mem_we    <= 1'b0;
                        done      <= 1'b0;
                        iss_cnt   <= IW'(1);
                        cap_cnt   <= '0;
                        hit_count <= '0;
                        rd_vld    <= {rd_vld[0], 1'b1};
                        state     <= READ;
                    end
                end
                READ: begin
                    mem_addr <= input_addr + 16'(iss_cnt);
                    rd_vld   <= {rd_vld[0], 1'b1};
                    if (iss_cnt == LAST)
                        state <= DRAIN;
                    else
                        iss_cnt <= iss_cnt + IW'(1);
                end
                DRAIN: begin
                    if (capture && cap_cnt == LAST)
                        state <= WR0;
                end
                WR0: begin
                    mem_we         <= 1'b1;
                    mem_addr       <= output_addr;
                    mem_write_data <= best_hash;
                    state          <= WR1;
                end
                WR1: begin
                    mem_we         <= 1'b1;
                    mem_addr       <= output_addr + 16'd1;
                    mem_write_data <= best_nonce;
                    state          <= WR2;
                end
                WR2: begin
                    mem_we         <= 1'b1;
                    mem_addr       <= output_addr + 16'd2;
                    mem_write_data <= 32'(hit_count);
                    state          <= FIN;
                end
                FIN: begin
                    mem_we <= 1'b0;
                    done   <= 1'b1;
                    found  <= (hit_count != '0);
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/nonce_scan.md
# nonce_scan

Post-processing stage that sits directly downstream of the double-SHA256 nonce hasher. The hasher writes one H0 word per nonce into the shared word-addressed memory; this block reads those NUM_NONCES words back. It finds the smallest hash and its nonce, counts the hashes strictly below a difficulty target, and writes a three-word result record to memory. It uses the same single-port synchronous memory interface as the hasher, so the two blocks can be muxed onto one RAM.

## Interface
- NUM_NONCES, 16, number of consecutive hash words to scan; legal range 2..256.
- CW, $clog2(NUM_NONCES+1), width of hit_count.
- clk  in  1  system clock; also drives the memory.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  begin a scan; sampled only in IDLE.
- input_addr  in  16  address of the hash word for nonce 0; nonce i is at input_addr+i.
- output_addr  in  16  base address of the 3-word result record.
- target  in  32  difficulty threshold; a hash is a hit when it is below target (unsigned, strict).
- mem_clk  out  1  equals clk (combinational).
- mem_we  out  1  memory write enable (registered).
- mem_addr  out  16  memory address (registered).
- mem_write_data  out  32  memory write data (registered).
- mem_read_data  in  32  memory read data.
- done  out  1  scan complete; held until the next accepted start or reset.
- found  out  1  hit_count != 0; valid while done=1.
- best_hash  out  32  minimum hash value seen.
- best_nonce  out  32  index of best_hash, zero-extended.
- hit_count  out  CW  number of hashes below target.

## Operation
- States: IDLE, READ, DRAIN, WR0, WR1, WR2, FIN.
- **IDLE**
  - If start=1: mem_addr<=input_addr, mem_we<=0, done<=0, issue and capture counters<=0, go to READ.
  - Otherwise hold all outputs.
- **READ**
  - Issue one address per cycle: mem_addr<=input_addr+k for k=1..NUM_NONCES-1.
  - Go to DRAIN after the last address is issued.
- **Capture**
  - Runs in READ and DRAIN.
  - Each word is captured 2 edges after its address edge. The capture for nonce j uses mem_read_data.
  - j=0 loads best_hash unconditionally and sets best_nonce=0.
  - For j>0: replace best only if hash<best_hash (unsigned, strict). On ties the earlier nonce is kept.
  - If hash<target: hit_count+=1.
- **Writes**
  - After the NUM_NONCES-th capture, go to WR0.
  - WR0, WR1, WR2 each drive mem_we<=1, with addresses output_addr+0/1/2.
  - Data: best_hash, best_nonce, {zero pad, hit_count}.
  - The write data uses the final values, including the last capture.
- **FIN**
  - mem_we<=0, done<=1, found<=(hit_count!=0), go to IDLE.
- **Arithmetic**
  - Address sums are modulo 2^16 (wrap, no error).
  - hit_count saturation is unnecessary because CW covers NUM_NONCES.
- **Busy behaviour**
  - start is ignored outside IDLE.
  - input_addr, output_addr and target must be held stable from start until done; they are not latched.
- **Reset**
  - Synchronous reset (reset_n=0 at an edge), including mid-scan or mid-write, forces IDLE.
  - All registered outputs return to 0: mem_we, mem_addr, mem_write_data, done, found, best_hash, best_nonce, hit_count.
  - A partially written record is not rolled back.

## Timing
- Edge 0 is the edge at which start is sampled in IDLE.
- Addresses are issued at edges 0..N-1, where N=NUM_NONCES.
- Captures occur at edges 2..N+1.
- Writes are registered at edges N+2, N+3, N+4. mem_we is high for exactly 3 cycles.
- mem_we falls and done rises at edge N+5. For N=16, done is high 21 cycles after start.
- mem_we is never high during READ or DRAIN.
- done=1 and start=1 in IDLE at the same edge: the new scan is accepted and done<=0 at that edge.
- reset_n=0 and start=1 at the same edge: reset wins.

## Test plan
- **Ascending hashes with threshold:** words 0x10000000+i (i=0..15), target 0x10000005. Required: best_hash=0x10000000, best_nonce=0, hit_count=5, found=1. Memory at output_addr..+2 = {0x10000000, 0, 5}. done rises exactly 21 cycles after start.
- **Descending hashes:** words 0xF0000000-i. Required: best_nonce=15, best_hash=0xEFFFFFF1. With target=0xFFFFFFFF: hit_count=16.
- **Tie on the minimum:** nonces 3 and 9 both equal 0x00000001, all others 0x80000000. Required: best_nonce=3.
- **No hits:** target=0 with arbitrary data. Required: hit_count=0, found=0, third record word=0. All-0xFFFFFFFF data gives best_nonce=0.
- **Reset mid-scan:** assert reset_n=0 for one cycle at edge 8. Required: the next cycle shows mem_we=0, done=0, all result outputs 0. A following start completes correctly with no stale state.
- **Address wrap and busy start:** input_addr=0xFFF8. Required: reads 0xFFF8..0x0007. Pulsing start during READ changes nothing. The record is written to output_addr unaffected.
